mux_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the 4-input multiplexer datapath (inputs a, b, c, d; selects s1, s0; output y).
- Four requesters share the mux. The block grants one requester at a time and drives the select lines registered.
- It presents the selected data with a valid flag.
- It bounds each grant to a maximum hold time, so no requester can starve the others.

---
 rtl/mux_arbiter.sv | 116 +++++++++++
 tb/tb_mux_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mux_arbiter.sv
// Round-robin arbiter driving a registered 4:1 mux select with a per-grant
// hold limit; y is the selected input, gated to zero while no grant is active.
module mux_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic             clock,
  input  logic             n_reset,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [3:0]       gnt,
  output logic             s1,
  output logic             s0,
  output logic [WIDTH-1:0] y,
  output logic             valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] ptr_q,   ptr_d;
  logic [7:0] hold_q,  hold_d;

  logic       found;
  logic [1:0] winner;
  logic [1:0] cand;
  logic       release_grant;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '1;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  // ptr always equals owner while granted, so one search from ptr+1 serves
  // both the idle search and the release search from owner+1; a lone
  // requesting owner is reached last, which yields the timeout re-grant.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign release_grant = !req[owner_q] || (hold_q == HOLD_LAST);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          owner_d = winner;
          ptr_d   = winner;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (release_grant) begin
          hold_d = '0;
          if (found) begin
            owner_d = winner;
            ptr_d   = winner;
          end else begin
            state_d = IDLE;
          end
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    y     = '0;
    s1    = owner_q[1];
    s0    = owner_q[0];
    if (state_q == GRANT) begin
      gnt   = 4'b0001 << owner_q;
      valid = 1'b1;
      unique case (owner_q)
        2'd0: y = a;
        2'd1: y = b;
        2'd2: y = c;
        default: y = d;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Randomized bench for mux_arbiter: three instances with different hold limits
// share stimulus and are each compared against a cycle-level reference model.
module tb_mux_arbiter;

  localparam int W = 4;
  localparam int NI = 3;
  localparam int MH [NI] = '{8, 2, 1};

  logic         clock = 1'b0;
  logic         n_reset = 1'b0;
  logic [3:0]   req = '0;
  logic [W-1:0] a = '0, b = '0, c = '0, d = '0;

  logic [3:0]   gnt   [NI];
  logic         s1    [NI];
  logic         s0    [NI];
  logic         valid [NI];
  logic [W-1:0] y     [NI];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: busy flag, current owner, last-owner pointer,
  // number of cycles the current grant has lasted, last select value.
  int m_busy  [NI];
  int m_owner [NI];
  int m_ptr   [NI];
  int m_held  [NI];
  int m_sel   [NI];

  always #5 clock = ~clock;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mux_arbiter #(.WIDTH(W), .MAX_HOLD(MH[g])) u_dut (
      .clock   (clock),
      .n_reset (n_reset),
      .req     (req),
      .a       (a),
      .b       (b),
      .c       (c),
      .d       (d),
      .gnt     (gnt[g]),
      .s1      (s1[g]),
      .s0      (s0[g]),
      .y       (y[g]),
      .valid   (valid[g])
    );
  end

  function automatic int rr_pick(input logic [3:0] r, input int last);
    for (int j = 1; j <= 4; j++) begin
      if (r[(last + j) % 4]) return (last + j) % 4;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] data_of(input int idx);
    case (idx)
      0: return a;
      1: return b;
      2: return c;
      default: return d;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_busy[k] = 0; m_owner[k] = 0; m_ptr[k] = 3; m_held[k] = 0; m_sel[k] = 0;
    end
  endtask

  always @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      model_reset();
    end else begin
      for (int k = 0; k < NI; k++) begin
        int w;
        if (m_busy[k] != 0 && req[m_owner[k]] && m_held[k] < MH[k]) begin
          m_held[k]++;
        end else begin
          w = rr_pick(req, m_ptr[k]);
          if (w >= 0) begin
            m_busy[k] = 1; m_owner[k] = w; m_ptr[k] = w; m_held[k] = 1; m_sel[k] = w;
          end else begin
            m_busy[k] = 0;
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      logic [3:0]   e_gnt;
      logic [W-1:0] e_y;
      e_gnt = (m_busy[k] != 0) ? 4'(1 << m_owner[k]) : 4'd0;
      e_y   = (m_busy[k] != 0) ? data_of(m_owner[k]) : '0;
      check($sformatf("gnt_mh%0d", MH[k]),   32'(gnt[k]),          32'(e_gnt));
      check($sformatf("sel_mh%0d", MH[k]),   32'({s1[k], s0[k]}),  32'(m_sel[k]));
      check($sformatf("valid_mh%0d", MH[k]), 32'(valid[k]),        32'(m_busy[k] != 0));
      check($sformatf("y_mh%0d", MH[k]),     32'(y[k]),            32'(e_y));
    end
  endtask

  task automatic drive(input logic [3:0] r, input int n);
    repeat (n) begin
      @(negedge clock);
      check_all();
      req = r;
    end
  endtask

  initial begin
    model_reset();
    a = 4'd1; b = 4'd0; c = 4'd0; d = 4'd0;
    drive(4'b0000, 2);
    n_reset = 1'b1;
    drive(4'b0001, 3);
    drive(4'b0000, 2);

    a = 4'h3; b = 4'h5; c = 4'h9; d = 4'hE;
    drive(4'b1111, 20);
    drive(4'b0000, 2);

    drive(4'b0101, 3);
    drive(4'b0100, 4);
    drive(4'b1000, 20);
    drive(4'b1001, 6);
    drive(4'b0000, 2);

    drive(4'b0100, 3);
    @(negedge clock);
    check_all();
    #2 n_reset = 1'b0;
    #1 check_all();
    drive(4'b1111, 1);
    n_reset = 1'b1;
    drive(4'b1111, 6);

    repeat (400) begin
      @(negedge clock);
      check_all();
      if ($urandom_range(0, 2) == 0) req = 4'($urandom);
      a = W'($urandom); b = W'($urandom); c = W'($urandom); d = W'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        #2 n_reset = 1'b0;
        #1 check_all();
        @(negedge clock);
        check_all();
        n_reset = 1'b1;
      end
    end
    @(negedge clock);
    check_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
